// File: rtl/dmem_byte_addr.sv
// dmem_byte_addr -- byte-addressed 32-bit data memory with RV32I load/store sizes.
//
// Ports
//   clk          single clock, all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   r_enable     load request this cycle
//   w_enable     store request this cycle (with r_enable: store legality rules apply)
//   funct3       RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   address      byte address
//   wr_data      store data, right-aligned
//   re_data      registered, extended load result (1-cycle latency, held otherwise)
//   ready        high when accesses are accepted (RUN state)
//   fault        one-cycle pulse for a rejected access
//   fault_cause  01 misaligned, 10 out of range, 11 illegal funct3; held until next fault
//   fsm_state    debug view of the FSM: 0 = INIT, 1 = RUN
//
// Handshake: an access is taken on every rising edge where
// (r_enable | w_enable) & ready. There is no other flow control; requests
// presented while ready = 0 are dropped, not stalled.
module dmem_byte_addr #(
  parameter int DEPTH     = 32,
  parameter int INIT_MODE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r_enable,
  input  logic        w_enable,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] wr_data,
  output logic [31:0] re_data,
  output logic        ready,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        fsm_state
);

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (INIT_MODE != 0) ? S_INIT : S_RUN;

  state_t         state, state_next;
  logic [AW-1:0]  init_cnt, init_cnt_next;
  logic [31:0]    mem [DEPTH];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RESET_STATE;
      init_cnt <= '0;
      ready    <= 1'b0;
    end else begin
      state    <= state_next;
      init_cnt <= init_cnt_next;
      // Registered so ready is low during reset even when the FSM resets into RUN.
      ready    <= (state_next == S_RUN);
    end
  end

  always_comb begin
    state_next    = state;
    init_cnt_next = init_cnt;
    case (state)
      S_INIT: begin
        init_cnt_next = init_cnt + AW'(1);
        if (init_cnt == AW'(DEPTH - 1)) begin
          state_next    = S_RUN;
          init_cnt_next = '0;
        end
      end
      S_RUN:   state_next = S_RUN;
      default: state_next = RESET_STATE;
    endcase
  end

  assign fsm_state = state;

  // ------------------------------------------------------- access decode
  logic [AW-1:0] word_idx;
  logic [1:0]    offset;
  logic          access, illegal, misaligned, out_of_range, any_fault;
  logic [1:0]    cause;

  assign word_idx = address[AW+1:2];
  assign offset   = address[1:0];
  assign access   = (r_enable | w_enable) & ready;

  always_comb begin
    illegal = 1'b0;
    if (w_enable) begin
      case (funct3)
        3'b000, 3'b001, 3'b010: illegal = 1'b0;
        default:                illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal = 1'b0;
        default:                                illegal = 1'b1;
      endcase
    end
  end

  assign misaligned   = ((funct3[1:0] == 2'b01) & address[0]) |
                        ((funct3 == 3'b010) & (offset != 2'b00));
  assign out_of_range = (address >= LIMIT);
  assign any_fault    = illegal | misaligned | out_of_range;

  always_comb begin
    cause = 2'b10;
    if (illegal)         cause = 2'b11;
    else if (misaligned) cause = 2'b01;
  end

  // ------------------------------------------------------ load/store data
  logic [31:0] old_word, load_val, store_rep, merged;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [3:0]  lane_mask;

  // Combinational read of the pre-edge contents gives read-old behaviour
  // when a load and store hit the same word on one edge.
  assign old_word = mem[word_idx];
  assign byte_sel = old_word[{offset, 3'b000} +: 8];
  assign half_sel = offset[1] ? old_word[31:16] : old_word[15:0];

  always_comb begin
    load_val = old_word;
    case (funct3)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_val = {24'h0, byte_sel};
      3'b101:  load_val = {16'h0, half_sel};
      default: load_val = old_word;
    endcase
  end

  always_comb begin
    lane_mask = 4'b0000;
    store_rep = wr_data;
    case (funct3)
      3'b000: begin
        lane_mask = 4'b0001 << offset;
        store_rep = {4{wr_data[7:0]}};
      end
      3'b001: begin
        lane_mask = offset[1] ? 4'b1100 : 4'b0011;
        store_rep = {2{wr_data[15:0]}};
      end
      3'b010: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  end

  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lane_mask[i]) merged[8*i +: 8] = store_rep[8*i +: 8];
    end
  end

  // ------------------------------------------------------------- memory
  logic          init_we, store_we;
  logic [31:0]   init_val;

  // While rst_n is held low the FSM sits at INIT index 0, so word 0 gets the
  // same value INIT writes right after release; no other word is touched.
  assign init_we  = (state == S_INIT) && (INIT_MODE != 0);
  assign init_val = (INIT_MODE == 1) ? 32'h0 : 32'(init_cnt);
  assign store_we = access & w_enable & ~any_fault;

  always_ff @(posedge clk) begin
    if (init_we)       mem[init_cnt] <= init_val;
    else if (store_we) mem[word_idx] <= merged;
  end

  // ------------------------------------------------------ output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_data     <= 32'h0;
      fault       <= 1'b0;
      fault_cause <= 2'b00;
    end else begin
      fault <= access & any_fault;
      if (access & any_fault)           fault_cause <= cause;
      if (access & r_enable & ~any_fault) re_data   <= load_val;
    end
  end

endmodule

// File: tb/tb_dmem_byte_addr.sv
module tb_dmem_byte_addr;

  // ---------------------------------------------------- clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        r_enable, w_enable;
  logic [2:0]  funct3;
  logic [31:0] address, wr_data;
  logic [31:0] re_data;
  logic        ready, fault, fsm_state;
  logic [1:0]  fault_cause;

  dmem_byte_addr #(.DEPTH(32), .INIT_MODE(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .r_enable    (r_enable),
    .w_enable    (w_enable),
    .funct3      (funct3),
    .address     (address),
    .wr_data     (wr_data),
    .re_data     (re_data),
    .ready       (ready),
    .fault       (fault),
    .fault_cause (fault_cause),
    .fsm_state   (fsm_state)
  );

  // ------------------------------------------------------- scoreboard
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] ref_mem [32];
  logic [31:0] exp_re;
  logic        exp_fault;
  logic [1:0]  exp_cause;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic model_init();
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'(i);
  endtask

  // ---------------------------------------------------- driver tasks
  task automatic apply_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    r_enable = 1'b0;
    w_enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_re    = 32'h0;
    exp_fault = 1'b0;
    exp_cause = 2'b00;
    check("rst_re_data", re_data, 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_cause", 32'(fault_cause), 32'h0);
    check("rst_ready", 32'(ready), 32'h0);
  endtask

  // Releases reset and counts cycles with ready low, bounded.
  task automatic release_and_wait(input string tag);
    int n;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    #1;
    if (!ready) n++;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (ready) break;
      n++;
    end
    check(tag, 32'(n), 32'd32);
    model_init();
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    r_enable = 1'b0;
    w_enable = 1'b0;
    @(posedge clk);
    #1;
    exp_fault = 1'b0;
    check({tag, "_re"}, re_data, exp_re);
    check({tag, "_flt"}, 32'(fault), 32'(exp_fault));
    check({tag, "_cause"}, 32'(fault_cause), 32'(exp_cause));
  endtask

  task automatic access(input bit r, input bit w, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data,
                        input string tag);
    int          size, off;
    bit          illegal, misal, oor, sgn;
    logic [31:0] word, v, bmask;
    @(negedge clk);
    r_enable = r;
    w_enable = w;
    funct3   = f3;
    address  = addr;
    wr_data  = data;
    @(posedge clk);
    #1;
    // reference model: RV32I size/alignment rules on a byte-addressed array
    if (w) illegal = !(f3 inside {3'd0, 3'd1, 3'd2});
    else   illegal = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    sgn   = !f3[2];
    misal = (addr % size) != 0;
    oor   = addr >= 32'd128;
    exp_fault = r | w ? (illegal | misal | oor) : 1'b0;
    if (exp_fault) begin
      exp_cause = illegal ? 2'b11 : misal ? 2'b01 : 2'b10;
    end else if (r | w) begin
      word = ref_mem[addr / 4];
      off  = int'(addr % 4);
      if (r) begin
        v = word >> (8 * off);
        if (size == 1) begin
          v = v & 32'hFF;
          if (sgn && v >= 32'd128) v = v - 32'd256;
        end else if (size == 2) begin
          v = v & 32'hFFFF;
          if (sgn && v >= 32'd32768) v = v - 32'd65536;
        end
        exp_re = v;
      end
      if (w) begin
        for (int k = 0; k < size; k++) begin
          bmask = 32'hFF << (8 * (off + k));
          word  = (word & ~bmask) | (((data >> (8 * k)) & 32'hFF) << (8 * (off + k)));
        end
        ref_mem[addr / 4] = word;
      end
    end
    check({tag, "_re"}, re_data, exp_re);
    check({tag, "_flt"}, 32'(fault), 32'(exp_fault));
    check({tag, "_cause"}, 32'(fault_cause), 32'(exp_cause));
    r_enable = 1'b0;
    w_enable = 1'b0;
  endtask

  task automatic random_ops(input int count);
    int          kind;
    logic [31:0] a;
    for (int i = 0; i < count; i++) begin
      kind = int'($urandom_range(0, 9));
      a    = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 135));
      if (kind < 2) idle("rnd_idle");
      else if (kind < 6) access(1'b1, 1'b0, 3'($urandom_range(0, 7)), a, $urandom(), "rnd_ld");
      else if (kind < 9) access(1'b0, 1'b1, 3'($urandom_range(0, 7)), a, $urandom(), "rnd_st");
      else access(1'b1, 1'b1, 3'($urandom_range(0, 7)), a, $urandom(), "rnd_ldst");
    end
  endtask

  // ---------------------------------------------------------- stimulus
  initial begin
    rst_n    = 1'b0;
    r_enable = 1'b0;
    w_enable = 1'b0;
    funct3   = 3'b000;
    address  = 32'h0;
    wr_data  = 32'h0;
    model_init();

    apply_reset();
    release_and_wait("init_len");

    access(1'b1, 1'b0, 3'b010, 32'h7C, 32'h0, "lw_7c");
    check("lw_7c_val", re_data, 32'h0000001F);

    access(1'b0, 1'b1, 3'b010, 32'h10, 32'h80FF7F01, "sw_10");
    access(1'b1, 1'b0, 3'b000, 32'h10, 32'h0, "lb_10");
    check("lb_10_val", re_data, 32'h00000001);
    access(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, "lb_13");
    check("lb_13_val", re_data, 32'hFFFFFF80);
    access(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, "lbu_13");
    check("lbu_13_val", re_data, 32'h00000080);
    access(1'b1, 1'b0, 3'b001, 32'h12, 32'h0, "lh_12");
    check("lh_12_val", re_data, 32'hFFFF80FF);
    access(1'b1, 1'b0, 3'b101, 32'h10, 32'h0, "lhu_10");
    check("lhu_10_val", re_data, 32'h00007F01);

    access(1'b0, 1'b1, 3'b000, 32'h11, 32'h000000AA, "sb_11");
    access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, "lw_10a");
    check("lw_10a_val", re_data, 32'h80FFAA01);
    access(1'b0, 1'b1, 3'b001, 32'h12, 32'h00001234, "sh_12");
    access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, "lw_10b");
    check("lw_10b_val", re_data, 32'h1234AA01);

    // rejected accesses
    access(1'b0, 1'b1, 3'b010, 32'h02, 32'hFFFFFFFF, "sw_mis");
    check("sw_mis_cause", 32'(fault_cause), 32'h1);
    idle("after_fault");
    access(1'b1, 1'b0, 3'b010, 32'h00, 32'h0, "lw_00");
    check("lw_00_val", re_data, 32'h0);
    access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, "lw_20a");
    access(1'b1, 1'b0, 3'b010, 32'h80, 32'h0, "lw_oor");
    check("lw_oor_cause", 32'(fault_cause), 32'h2);
    access(1'b1, 1'b0, 3'b011, 32'h03, 32'h0, "ld_ill");
    check("ld_ill_cause", 32'(fault_cause), 32'h3);
    check("ld_ill_re", re_data, 32'h8);

    // same-edge load and store to one word returns the old contents
    access(1'b1, 1'b1, 3'b010, 32'h20, 32'hDEADBEEF, "ldst_20");
    check("ldst_20_val", re_data, 32'h8);
    access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, "lw_20b");
    check("lw_20b_val", re_data, 32'hDEADBEEF);

    random_ops(400);

    // reset during INIT restarts the sweep from index 0
    apply_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    apply_reset();
    release_and_wait("reinit_len");
    access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, "lw_20_reinit");
    random_ops(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_byte_addr.md
DMEM_BYTE_ADDR -- requirements
Module: dmem_byte_addr

Interface
REQ-001 Parameter DEPTH, default 32, number of 32-bit words; power of two, 4..4096.
REQ-002 Parameter INIT_MODE, default 2: 0 = no init, 1 = clear to zero, 2 = load word index (word i = i).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 r_enable  in  1  load request this cycle.
REQ-006 w_enable  in  1  store request this cycle.
REQ-007 funct3  in  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 address  in  32  byte address.
REQ-009 wr_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 re_data  out  32  registered, extended load result.
REQ-011 ready  out  1  high when the block accepts accesses.
REQ-012 fault  out  1  registered one-cycle pulse for a rejected access.
REQ-013 fault_cause  out  2  01 misaligned, 10 out of range, 11 illegal funct3; held until the next fault.

Function
REQ-014 Word index = address[log2(DEPTH)+1:2]; byte offset = address[1:0].
REQ-015 Access = (r_enable | w_enable) & ready, sampled on a rising edge; ignored while ready = 0.
REQ-016 Illegal: load funct3 not in {000,001,010,100,101}; store funct3 not in {000,001,010}; r_enable & w_enable together use the store rule.
REQ-017 Misaligned: half (001/101) with address[0]=1; word (010) with address[1:0]!=00.
REQ-018 Out of range: address >= 4*DEPTH.
REQ-019 Fault priority: illegal > misaligned > out of range; one fault pulse per faulting access.
REQ-020 A faulting access neither modifies memory nor updates re_data.
REQ-021 SB writes wr_data[7:0] to byte lane offset only; SH writes wr_data[15:0] to lanes {1,0} (offset 00) or {3,2} (offset 10); SW writes all 4 lanes; other lanes unchanged.
REQ-022 Load: re_data is updated at the same edge that samples r_enable and is visible the following cycle (1-cycle latency).
REQ-023 LB/LH sign-extend the selected byte/half; LBU/LHU zero-extend; LW returns the whole word.
REQ-024 Simultaneous load and store to the same word returns the pre-write contents (read-old); the store takes effect.
REQ-025 re_data holds its value in cycles with no valid load.
REQ-026 FSM states INIT and RUN; reset release enters INIT if INIT_MODE != 0, else RUN.
REQ-027 INIT writes one word per cycle, indices 0..DEPTH-1, then enters RUN; duration DEPTH cycles; ready = 0 in INIT, 1 in RUN.
REQ-028 INIT_MODE = 0: memory contents are undefined until written.

Reset
REQ-029 While rst_n = 0: re_data = 0, fault = 0, fault_cause = 00, ready = 0, init counter = 0.
REQ-030 Reset asserted mid-INIT or mid-RUN aborts immediately; after release, INIT restarts from index 0 (INIT_MODE != 0).
REQ-031 Memory array is not cleared by reset itself, only by INIT.

Verification
REQ-032 DEPTH=32, INIT_MODE=2, release reset -> ready low for 32 cycles, then high; LW 0x7C -> re_data = 0x0000001F one cycle later.
REQ-033 SW 0x10 data 0x80FF7F01; LB 0x10 -> 0x00000001; LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LH 0x12 -> 0xFFFF80FF; LHU 0x10 -> 0x00007F01.
REQ-034 After REQ-033: SB 0x11 data 0xAA, then LW 0x10 -> 0x80FFAA01; SH 0x12 data 0x1234, then LW 0x10 -> 0x1234AA01.
REQ-035 SW 0x02 -> fault pulse, cause 01, word 0 unchanged; LW 0x80 (DEPTH=32) -> cause 10; load funct3 011 at 0x03 -> cause 11 (priority over misaligned); re_data unchanged in all three.
REQ-036 Same-edge LW and SW at 0x20 (old 8, new 0xDEADBEEF) -> re_data = 8; next LW 0x20 -> 0xDEADBEEF; reset pulsed at INIT cycle 10 -> ready stays low a full 32 cycles after release.
